// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit: access sizes,
// controller states, byte-enable patterns and lane helpers.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mau_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      default:   mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = BE_BYTE0 << off;
      SIZE_HALF: be = off[1] ? BE_HALF_HI : BE_HALF_LO;
      SIZE_WORD: be = BE_WORD;
      default:   be = BE_WORD;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data so every enabled lane carries it.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{wd[7:0]}};
      SIZE_HALF: lanes = {2{wd[15:0]}};
      default:   lanes = wd;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ready bus between the MEM-stage access unit (master)
// and the data memory (slave).
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ready, dm_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Load formatter: picks the addressed byte/half lane out of a read word and
// sign- or zero-extends it; word loads pass through unchanged.
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data_o = rdata_i;
    case (off_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (size_i)
      SIZE_BYTE: data_o = {{24{signed_i & byte_s[7]}}, byte_s};
      SIZE_HALF: data_o = {{16{signed_i & half_s[15]}}, half_s};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: turns EX/MEM load/store controls
// into one req/ready bus transaction, stalling upstream until it completes.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [1:0]        MEM_MemSize,
  input  logic              MEM_MemSigned,
  input  logic [31:0]       MEM_aluResult,
  input  logic [31:0]       MEM_writeData,
  mem_access_unit_if.master dm,
  output logic [31:0]       MEM_dmOut,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              mem_buserr
);

  localparam logic             TO_EN   = (TIMEOUT != 32'd0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 32'd1);

  mau_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      dmout_q, dmout_d;
  logic             misalign_q, misalign_d;
  logic             buserr_q, buserr_d;

  logic             access_s;
  logic             misalign_s;
  logic [31:0]      load_fmt_s;

  assign access_s   = MEM_MemRead | MEM_MemWrite;
  assign misalign_s = is_misaligned(MEM_MemSize, MEM_aluResult[1:0]);

  // Formatting uses the latched lane/size so BUSY-time input changes are ignored.
  mem_load_align u_load_align (
    .rdata_i  (dm.dm_rdata),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (load_fmt_s)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    dmout_d    = dmout_q;
    misalign_d = 1'b0;
    buserr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_s && misalign_s) begin
          misalign_d = 1'b1;
          dmout_d    = 32'h0000_0000;
        end else if (access_s) begin
          req_d   = 1'b1;
          we_d    = MEM_MemWrite;
          addr_d  = {MEM_aluResult[31:2], 2'b00};
          be_d    = calc_be(MEM_MemSize, MEM_aluResult[1:0]);
          wdata_d = store_lanes(MEM_MemSize, MEM_writeData);
          off_d   = MEM_aluResult[1:0];
          size_d  = MEM_MemSize;
          sgn_d   = MEM_MemSigned;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dm.dm_ready) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!we_q) begin
            dmout_d = load_fmt_s;
          end else begin
            dmout_d = dmout_q;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          cnt_d    = cnt_q + CNT_W'(1);
          req_d    = 1'b0;
          dmout_d  = 32'h0000_0000;
          buserr_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0000_0000;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0000_0000;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      dmout_q    <= 32'h0000_0000;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      dmout_q    <= dmout_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
    end
  end

  assign dm.dm_req    = req_q;
  assign dm.dm_we     = we_q;
  assign dm.dm_addr   = addr_q;
  assign dm.dm_be     = be_q;
  assign dm.dm_wdata  = wdata_q;
  assign MEM_dmOut    = dmout_q;
  assign mem_misalign = misalign_q;
  assign mem_buserr   = buserr_q;

  // Stall is 0 in DONE so the pipeline advances exactly once per access.
  assign mem_stall = ((state_q == ST_IDLE) & access_s & ~misalign_s) | (state_q == ST_BUSY);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset
// abort sequence and randomized accesses against a transaction-level model.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] daddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] dmout;
    int          stall;
    int          reqs;
    int          mis;
    int          berr;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [1:0]  MEM_MemSize;
  logic        MEM_MemSigned;
  logic [31:0] MEM_aluResult;
  logic [31:0] MEM_writeData;
  logic [31:0] MEM_dmOut;
  logic        mem_stall;
  logic        mem_misalign;
  logic        mem_buserr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .MEM_MemRead   (MEM_MemRead),
    .MEM_MemWrite  (MEM_MemWrite),
    .MEM_MemSize   (MEM_MemSize),
    .MEM_MemSigned (MEM_MemSigned),
    .MEM_aluResult (MEM_aluResult),
    .MEM_writeData (MEM_writeData),
    .dm            (bus),
    .MEM_dmOut     (MEM_dmOut),
    .mem_stall     (mem_stall),
    .mem_misalign  (mem_misalign),
    .mem_buserr    (mem_buserr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  // Transaction-level expectation built from the access rules with plain arithmetic.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev);
    int          nb;
    int          off;
    logic        mis;
    logic [31:0] mask;
    logic [31:0] lv;
    nb  = (v.size == 2'b00) ? 1 : ((v.size == 2'b01) ? 2 : 4);
    off = int'(v.addr[1:0]);
    mis = (off % nb) != 0;
    v.daddr = v.addr & 32'hFFFF_FFFC;
    v.be    = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) v.wdata[i*8 +: 8] = v.wd[(i % nb)*8 +: 8];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (nb * 8)) - 32'd1);
    lv   = (v.rdata >> (off * 8)) & mask;
    if (v.sgn && nb < 4 && lv[nb*8-1]) lv = lv | ~mask;
    v.mis = 0; v.berr = 0; v.stall = 0; v.reqs = 0; v.dmout = prev;
    if (!(v.rd || v.wr)) begin
      v.dmout = prev;
    end else if (mis) begin
      v.mis = 1; v.dmout = 32'h0;
    end else if (v.waits >= TIMEOUT) begin
      v.stall = TIMEOUT + 1; v.reqs = TIMEOUT; v.berr = 1; v.dmout = 32'h0;
    end else begin
      v.stall = v.waits + 2; v.reqs = v.waits + 1;
      v.dmout = (v.rd && !v.wr) ? lv : prev;
    end
    return v;
  endfunction

  // Present one access, act as the memory, then idle two cycles to catch flag pulses.
  task automatic run_access(input vec_t v, input string tag);
    int          stall_n, req_n, mis_n, berr_n;
    logic        stable, done;
    logic [31:0] dmout_seen;
    stall_n = 0; req_n = 0; mis_n = 0; berr_n = 0;
    stable = 1'b1; done = 1'b0; dmout_seen = 32'h0;
    MEM_MemRead = v.rd; MEM_MemWrite = v.wr; MEM_MemSize = v.size;
    MEM_MemSigned = v.sgn; MEM_aluResult = v.addr; MEM_writeData = v.wd;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (mem_stall) stall_n++;
      if (mem_misalign) mis_n++;
      if (mem_buserr) berr_n++;
      if (bus.dm_req) begin
        req_n++;
        if (bus.dm_we !== v.wr || bus.dm_addr !== v.daddr ||
            bus.dm_be !== v.be || bus.dm_wdata !== v.wdata) stable = 1'b0;
        if (req_n == v.waits + 1) begin
          bus.dm_ready = 1'b1;
          bus.dm_rdata = v.rdata;
        end
      end
      if (!mem_stall) done = 1'b1;
      @(posedge clk); #1;
      bus.dm_ready = 1'b0;
      bus.dm_rdata = $urandom;
    end
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) dmout_seen = MEM_dmOut;
      if (mem_stall) stall_n++;
      if (mem_misalign) mis_n++;
      if (mem_buserr) berr_n++;
      @(posedge clk); #1;
    end
    check({tag, " finished"}, 32'(done), 32'd1);
    check({tag, " stall cycles"}, stall_n, v.stall);
    check({tag, " req cycles"}, req_n, v.reqs);
    check({tag, " bus fields"}, 32'(stable), 32'd1);
    check({tag, " misalign pulses"}, mis_n, v.mis);
    check({tag, " buserr pulses"}, berr_n, v.berr);
    check({tag, " dmOut"}, dmout_seen, v.dmout);
  endtask

  vec_t        tbl [10];
  vec_t        rv;
  logic [31:0] dm_prev;
  int          sel;

  initial begin
    //         rd    wr    size   sgn   addr          wd            rdata         w   daddr         be       wdata         dmout        st rq ms be
    tbl[0] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0000_0000, 32'h80AB_CDEF, 0,  32'h0000_1000, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 2, 1, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0000_0000, 3,  32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80, 5, 4, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0000_0000, 32'h0000_0000, 0,  32'h0000_3000, 4'b1111, 32'h0000_0000, 32'h0000_0000, 0, 0, 1, 0};
    tbl[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h1234_5678, 32'hFFFF_8000, 99, 32'h0000_4000, 4'b1100, 32'h5678_5678, 32'h0000_0000, 17, 16, 0, 1};
    tbl[4] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0000_0000, 32'hCAFE_F00D, 2,  32'h0000_6000, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D, 4, 3, 0, 0};
    tbl[5] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_5000, 32'hDEAD_BEEF, 32'h1111_1111, 1,  32'h0000_5000, 4'b1111, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3, 2, 0, 0};
    tbl[6] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_7001, 32'h0000_00FF, 32'h0000_A500, 0,  32'h0000_7000, 4'b0010, 32'hFFFF_FFFF, 32'h0000_00A5, 2, 1, 0, 0};
    tbl[7] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_7000, 32'h0000_0000, 32'h1234_F00F, 0,  32'h0000_7000, 4'b0011, 32'h0000_0000, 32'hFFFF_F00F, 2, 1, 0, 0};
    tbl[8] = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_9000, 32'h0000_0000, 32'h0000_0000, 0,  32'h0000_9000, 4'b1111, 32'h0000_0000, 32'hFFFF_F00F, 0, 0, 0, 0};
    tbl[9] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_8002, 32'h0000_005A, 32'h0000_0000, 0,  32'h0000_8000, 4'b0100, 32'h5A5A_5A5A, 32'hFFFF_F00F, 2, 1, 0, 0};

    rst = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_MemSize = 2'b00; MEM_MemSigned = 1'b0;
    MEM_aluResult = 32'h0; MEM_writeData = 32'h0;
    bus.dm_ready = 1'b0; bus.dm_rdata = 32'h0;
    #3;
    check("reset bus outputs", {bus.dm_req, bus.dm_we, bus.dm_addr, bus.dm_be, bus.dm_wdata} == 70'h0 ? 32'd1 : 32'd0, 32'd1);
    check("reset dmOut", MEM_dmOut, 32'h0);
    check("reset flags", {30'h0, mem_misalign, mem_buserr}, 32'h0);
    check("reset stall", 32'(mem_stall), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 10; i++) run_access(tbl[i], $sformatf("vec%0d", i));

    // Reset pulled mid-BUSY: everything clears at once and late dm_ready is ignored.
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_MemSize = 2'b10; MEM_aluResult = 32'h0000_8000;
    repeat (3) @(negedge clk);
    check("rst pre busy req", 32'(bus.dm_req), 32'd1);
    #2;
    rst = 1'b0;
    MEM_MemRead = 1'b0;
    #1;
    check("rst async bus", {bus.dm_req, bus.dm_we, bus.dm_addr, bus.dm_be, bus.dm_wdata} == 70'h0 ? 32'd1 : 32'd0, 32'd1);
    check("rst async dmOut", MEM_dmOut, 32'h0);
    check("rst async stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.dm_ready = 1'b1; bus.dm_rdata = 32'h8765_4321;
    repeat (3) @(negedge clk);
    check("rst after req", 32'(bus.dm_req), 32'h0);
    check("rst after dmOut", MEM_dmOut, 32'h0);
    check("rst after stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    bus.dm_ready = 1'b0;
    dm_prev = 32'h0;

    for (int i = 0; i < 60; i++) begin
      sel      = $urandom_range(0, 3);
      rv.rd    = sel[0];
      rv.wr    = sel[1];
      rv.size  = 2'($urandom_range(0, 3));
      rv.sgn   = 1'($urandom_range(0, 1));
      rv.addr  = $urandom;
      rv.wd    = $urandom;
      rv.rdata = $urandom;
      rv.waits = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      rv = model(rv, dm_prev);
      run_access(rv, $sformatf("rand%0d", i));
      dm_prev = rv.dmout;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
